// File: rtl/clk_div_mux_if.sv
// Switch-request handshake and packed divide-ratio bus for clk_div_mux.
interface clk_div_mux_if #(
  parameter int unsigned NUM_SEL = 4,
  parameter int unsigned CNT_W   = 8
);
  localparam int unsigned SEL_W = $clog2(NUM_SEL);

  logic [NUM_SEL*CNT_W-1:0] div_i;
  logic [SEL_W-1:0]         sel_i;
  logic                     req_i;
  logic                     ack_o;
  logic                     err_o;
  logic [SEL_W-1:0]         cur_sel_o;

  modport master (output div_i, sel_i, req_i, input ack_o, err_o, cur_sel_o);
  modport slave  (input div_i, sel_i, req_i, output ack_o, err_o, cur_sel_o);
endinterface

// File: rtl/clk_div_mux.sv
// Glitch-free programmable clock divider/selector; ratio changes land only on clk_o rise.
// Optional clock gating via macro CLK_DIV_MUX_GATE_EN (adds en_i).
module clk_div_mux #(
  parameter int unsigned NUM_SEL = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef CLK_DIV_MUX_GATE_EN
  input  logic        en_i,
`endif
  clk_div_mux_if.slave bus,
  output logic        clk_o
);
  localparam int unsigned SEL_W = $clog2(NUM_SEL);

  typedef enum logic {ST_LO = 1'b0, ST_HI = 1'b1} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] d_q;
  logic             pending_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] cur_sel_q;
  logic             ack_q;
  logic             err_q;
  logic             clk_q;

  logic             en_c;
  logic             capture_c;
  logic             sel_bad_c;
  logic [SEL_W-1:0] new_sel_d;
  logic [CNT_W-1:0] new_div_d;

`ifdef CLK_DIV_MUX_GATE_EN
  assign en_c = en_i;
`else
  assign en_c = 1'b1;
`endif

  // Channel and ratio that take effect at the next rise boundary.
  always_comb begin
    new_sel_d = pending_q ? sel_q : cur_sel_q;
    new_div_d = '0;
    for (int unsigned k = 0; k < NUM_SEL; k++) begin
      if (new_sel_d == SEL_W'(k)) new_div_d = bus.div_i[k*CNT_W +: CNT_W];
    end
  end

  assign sel_bad_c = 32'(bus.sel_i) >= NUM_SEL;
  assign capture_c = bus.req_i && !pending_q && !ack_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_LO;
      cnt_q     <= '0;
      d_q       <= '0;
      pending_q <= 1'b0;
      sel_q     <= '0;
      cur_sel_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      clk_q     <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;

      // Illegal channels are rejected immediately and never become pending.
      if (capture_c) begin
        if (sel_bad_c) begin
          ack_q <= 1'b1;
          err_q <= 1'b1;
        end else begin
          sel_q     <= bus.sel_i;
          pending_q <= 1'b1;
        end
      end

      if (cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end else if (state_q == ST_HI) begin
        clk_q   <= 1'b0;
        state_q <= ST_LO;
        cnt_q   <= d_q;
      end else begin
        // Rise boundary: the only point where channel and ratio may change.
        if (pending_q) begin
          cur_sel_q <= sel_q;
          pending_q <= 1'b0;
          ack_q     <= 1'b1;
        end
        d_q <= new_div_d;
        if (en_c) begin
          cnt_q   <= new_div_d;
          clk_q   <= 1'b1;
          state_q <= ST_HI;
        end
      end
    end
  end

  assign bus.ack_o     = ack_q;
  assign bus.err_o     = err_q;
  assign bus.cur_sel_o = cur_sel_q;
  assign clk_o         = clk_q;
endmodule
